pkt_producer: RTL and testbench

PKT_PRODUCER -- requirements
Module: pkt_producer

---
 rtl/pkt_producer_if.sv | 9 +
 rtl/pkt_producer.sv | 103 ++++++++++
 tb/tb_pkt_producer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pkt_producer_if.sv
// Producer-side FIFO write port: push strobe and data out, full flag back.
interface pkt_producer_if;
   logic        wfull;
   logic        wpush;
   logic [15:0] wdata;

   modport master (input wfull, output wpush, output wdata);
   modport slave  (output wfull, input wpush, input wdata);
endinterface

// File: rtl/pkt_producer.sv
// Frame producer: pushes header {HDR_TAG,len}, len incrementing payload words
// starting at seed, then a 16-bit wrapping checksum of header and payload.
module pkt_producer #(
   parameter logic [7:0] HDR_TAG = 8'hA5
) (
   input  logic                wclk,
   input  logic                wrst_n,
   input  logic                start,
   input  logic [7:0]          len,
   input  logic [15:0]         seed,
   pkt_producer_if.master      fifo,
   output logic                busy,
   output logic                done
);

   localparam int unsigned LEN_W  = 8;
   localparam int unsigned DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      PAY  = 2'd2,
      SUM  = 2'd3
   } state_t;

   state_t              state;
   logic [LEN_W-1:0]    len_q;
   logic [DATA_W-1:0]   seed_q;
   logic [LEN_W-1:0]    cnt;
   logic [DATA_W-1:0]   acc;
   logic [DATA_W-1:0]   wdata_q;
   logic                xfer;
   logic [DATA_W-1:0]   acc_nxt;

   // A word moves whenever a frame is active and the FIFO has room.
   assign xfer       = (state != IDLE) && !fifo.wfull;
   assign fifo.wpush = xfer;
   assign fifo.wdata = wdata_q;
   assign acc_nxt    = acc + wdata_q;

   // wdata is preloaded one step ahead so it is stable while stalled.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state   <= IDLE;
         len_q   <= '0;
         seed_q  <= '0;
         cnt     <= '0;
         acc     <= '0;
         wdata_q <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  len_q   <= len;
                  seed_q  <= seed;
                  cnt     <= '0;
                  acc     <= '0;
                  wdata_q <= {HDR_TAG, len};
                  busy    <= 1'b1;
                  state   <= HDR;
               end
            end
            HDR: begin
               if (xfer) begin
                  acc <= acc_nxt;
                  if (len_q != '0) begin
                     wdata_q <= seed_q;
                     cnt     <= '0;
                     state   <= PAY;
                  end else begin
                     wdata_q <= acc_nxt;
                     state   <= SUM;
                  end
               end
            end
            PAY: begin
               if (xfer) begin
                  acc <= acc_nxt;
                  if (cnt == len_q - LEN_W'(1)) begin
                     wdata_q <= acc_nxt;
                     state   <= SUM;
                  end else begin
                     cnt     <= cnt + LEN_W'(1);
                     wdata_q <= wdata_q + DATA_W'(1);
                  end
               end
            end
            SUM: begin
               if (xfer) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pkt_producer.sv
// Directed bench for pkt_producer: table of frames plus stall, ignored-start,
// back-to-back and mid-frame reset sequences.
module tb_pkt_producer;

   logic        wclk;
   logic        wrst_n;
   logic        start;
   logic [7:0]  len;
   logic [15:0] seed;
   logic        busy;
   logic        done;

   pkt_producer_if fifo ();

   pkt_producer #(.HDR_TAG(8'hA5)) dut (
      .wclk  (wclk),
      .wrst_n(wrst_n),
      .start (start),
      .len   (len),
      .seed  (seed),
      .fifo  (fifo),
      .busy  (busy),
      .done  (done)
   );

   typedef struct {
      logic [7:0]  len;
      logic [15:0] seed;
      logic [15:0] exp_hdr;
      logic [15:0] exp_sum;
   } frame_vec_t;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int hdr_cyc;
   int sum_cyc;

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;
   always @(posedge wclk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running, required finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge wclk);
      #1;
   endtask

   // Runs one unstalled frame; returns in the done cycle so a start can coincide with it.
   task automatic run_frame(input logic [7:0] l, input logic [15:0] s,
                            input logic [15:0] hdr, input logic [15:0] sum);
      logic [15:0] exp_w;
      start = 1'b1; len = l; seed = s;
      tick();
      start = 1'b0;
      for (int i = 0; i < int'(l) + 2; i++) begin
         if (i == 0) begin
            exp_w   = hdr;
            hdr_cyc = cyc;
         end else if (i == int'(l) + 1) begin
            exp_w   = sum;
            sum_cyc = cyc;
         end else begin
            exp_w = s + 16'(i - 1);
         end
         chk($sformatf("push[%0d]", i), 32'(fifo.wpush), 32'd1);
         chk($sformatf("wdata[%0d]", i), 32'(fifo.wdata), 32'(exp_w));
         chk($sformatf("busy[%0d]", i), 32'(busy), 32'd1);
         tick();
      end
      chk("done_pulse", 32'(done), 32'd1);
      chk("busy_end", 32'(busy), 32'd0);
      chk("push_end", 32'(fifo.wpush), 32'd0);
   endtask

   frame_vec_t vecs [5];
   int prev_sum;

   initial begin
      vecs[0] = '{len: 8'd3, seed: 16'h0010, exp_hdr: 16'hA503, exp_sum: 16'hA536};
      vecs[1] = '{len: 8'd0, seed: 16'h7777, exp_hdr: 16'hA500, exp_sum: 16'hA500};
      vecs[2] = '{len: 8'd3, seed: 16'hFFFE, exp_hdr: 16'hA503, exp_sum: 16'hA500};
      vecs[3] = '{len: 8'd1, seed: 16'h1234, exp_hdr: 16'hA501, exp_sum: 16'hB735};
      vecs[4] = '{len: 8'd2, seed: 16'h8000, exp_hdr: 16'hA502, exp_sum: 16'hA503};

      wrst_n = 1'b0; start = 1'b0; len = 8'd0; seed = 16'd0; fifo.wfull = 1'b0;
      #1;
      chk("rst_push", 32'(fifo.wpush), 32'd0);
      chk("rst_wdata", 32'(fifo.wdata), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      tick(); tick();
      wrst_n = 1'b1;

      // Start on the first edge after reset release.
      for (int v = 0; v < 5; v++) begin
         run_frame(vecs[v].len, vecs[v].seed, vecs[v].exp_hdr, vecs[v].exp_sum);
         tick();
         chk("done_clear", 32'(done), 32'd0);
      end

      // Backpressure on payload word 0011.
      start = 1'b1; len = 8'd3; seed = 16'h0010;
      tick();
      start = 1'b0;
      chk("bp_hdr", 32'(fifo.wdata), 32'hA503);
      tick();
      chk("bp_w0", 32'(fifo.wdata), 32'h0010);
      tick();
      fifo.wfull = 1'b1;
      for (int j = 0; j < 4; j++) begin
         #1;
         chk($sformatf("bp_stall_push[%0d]", j), 32'(fifo.wpush), 32'd0);
         chk($sformatf("bp_stall_data[%0d]", j), 32'(fifo.wdata), 32'h0011);
         chk($sformatf("bp_stall_busy[%0d]", j), 32'(busy), 32'd1);
         tick();
      end
      fifo.wfull = 1'b0;
      #1;
      chk("bp_w1_push", 32'(fifo.wpush), 32'd1);
      chk("bp_w1", 32'(fifo.wdata), 32'h0011);
      tick();
      chk("bp_w2", 32'(fifo.wdata), 32'h0012);
      tick();
      chk("bp_sum", 32'(fifo.wdata), 32'hA536);
      chk("bp_sum_push", 32'(fifo.wpush), 32'd1);
      tick();
      chk("bp_done", 32'(done), 32'd1);
      tick();

      // Start while busy must not disturb the frame.
      start = 1'b1; len = 8'd2; seed = 16'h0100;
      tick();
      len = 8'd5; seed = 16'h5555;
      chk("ign_hdr", 32'(fifo.wdata), 32'hA502);
      tick();
      chk("ign_w0", 32'(fifo.wdata), 32'h0100);
      start = 1'b0;
      tick();
      chk("ign_w1", 32'(fifo.wdata), 32'h0101);
      tick();
      chk("ign_sum", 32'(fifo.wdata), 32'hA703);
      tick();
      chk("ign_done", 32'(done), 32'd1);
      tick();
      chk("ign_idle_push", 32'(fifo.wpush), 32'd0);
      chk("ign_idle_busy", 32'(busy), 32'd0);

      // Back-to-back: second start coincides with done.
      run_frame(8'd1, 16'h0001, 16'hA501, 16'hA502);
      prev_sum = sum_cyc;
      run_frame(8'd0, 16'h0000, 16'hA500, 16'hA500);
      chk("b2b_gap", 32'(hdr_cyc - prev_sum), 32'd2);
      tick();

      // Reset during payload abandons the frame.
      start = 1'b1; len = 8'd4; seed = 16'h0020;
      tick();
      start = 1'b0;
      tick(); tick();
      chk("rm_in_pay", 32'(fifo.wdata), 32'h0021);
      #2 wrst_n = 1'b0;
      #1;
      chk("rm_push", 32'(fifo.wpush), 32'd0);
      chk("rm_busy", 32'(busy), 32'd0);
      chk("rm_done", 32'(done), 32'd0);
      chk("rm_wdata", 32'(fifo.wdata), 32'd0);
      tick();
      wrst_n = 1'b1;
      for (int j = 0; j < 3; j++) begin
         tick();
         chk($sformatf("rm_idle_push[%0d]", j), 32'(fifo.wpush), 32'd0);
         chk($sformatf("rm_idle_busy[%0d]", j), 32'(busy), 32'd0);
      end
      run_frame(8'd2, 16'h0005, 16'hA502, 16'hA50D);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
